// File: rtl/pika_pkg.sv
// Shared court geometry, fixed-point format and player state encoding.
// Used by the player controller, the ball physics and the renderer.
package pika_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int NET_X    = 154;
  localparam int NET_W    = 12;
  localparam int PIKA_W   = 60;
  localparam int PIKA_H   = 60;
  localparam int FRAC_W   = 6;
  localparam int GROUND_Y = SCREEN_H - PIKA_H;

  localparam int POS_W = 10;
  localparam int VY_W  = 10;
  localparam int YFX_W = 16;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_SMASH  = 2'd2
  } pika_state_e;

endpackage

// File: rtl/pika_player_ctrl_if.sv
// Player-side bundle between the input front end, the controller and the physics engine.
// The master drives frame timing and buttons; the slave (controller) drives sprite state.
interface pika_player_ctrl_if;
  import pika_pkg::*;

  logic             frame_tick;
  logic             btn_left;
  logic             btn_right;
  logic             btn_jump;
  logic             btn_smash;
  logic             round_reset;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic             op_move_left;
  logic             op_move_right;
  logic             op_jump;
  logic             is_smash;
  logic             on_ground;

  modport master (
    output frame_tick, btn_left, btn_right, btn_jump, btn_smash, round_reset,
    input  pos_x, pos_y, op_move_left, op_move_right, op_jump, is_smash, on_ground
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_jump, btn_smash, round_reset,
    output pos_x, pos_y, op_move_left, op_move_right, op_jump, is_smash, on_ground
  );

endinterface

// File: rtl/btn_edge_latch.sv
// Rising-edge detector with a sticky request flag that holds until the next frame consumes it.
// An edge arriving in the consuming cycle is visible on o_req immediately.
module btn_edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_consume,
  input  logic i_clear,
  output logic o_req
);

  logic r_prev;
  logic r_req;
  logic w_rise;

  assign w_rise = i_btn & ~r_prev;
  assign o_req  = r_req | w_rise;

  // Clear keeps tracking the button level so a held button does not fake an edge afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_req  <= 1'b0;
    end else begin
      r_prev <= i_btn;
      if (i_clear || i_consume) begin
        r_req <= 1'b0;
      end else if (w_rise) begin
        r_req <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pika_player_ctrl.sv
// Per-player motion controller: buttons to sprite position, airborne/smash state and move flags.
// All motion advances on frame_tick; round_reset respawns the player on the following clock.
module pika_player_ctrl #(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = pika_pkg::NET_X - pika_pkg::PIKA_W,
  parameter int INIT_X       = 36,
  parameter int GROUND_Y     = pika_pkg::GROUND_Y,
  parameter int MOVE_STEP    = 4,
  parameter int JUMP_VEL     = -448,
  parameter int GRAVITY      = 16,
  parameter int MAX_FALL_VEL = 511,
  parameter int SMASH_FRAMES = 8,
  parameter int SMASH_COOL   = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  pika_player_ctrl_if.slave  io_bus
);
  import pika_pkg::*;

  localparam int CNT_W  = $clog2(SMASH_FRAMES + 1);
  localparam int COOL_W = $clog2(SMASH_COOL + 1);

  localparam logic [POS_W-1:0]        L_X_MIN      = POS_W'(X_MIN);
  localparam logic [POS_W-1:0]        L_X_MAX      = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]        L_INIT_X     = POS_W'(INIT_X);
  localparam logic [POS_W-1:0]        L_STEP       = POS_W'(MOVE_STEP);
  localparam logic [POS_W-1:0]        L_LEFT_LIM   = POS_W'(X_MIN + MOVE_STEP);
  localparam logic [POS_W-1:0]        L_RIGHT_LIM  = POS_W'(X_MAX - MOVE_STEP);
  localparam logic [YFX_W-1:0]        L_GROUND_FX  = YFX_W'(GROUND_Y << FRAC_W);
  localparam logic signed [YFX_W:0]   L_GROUND_CMP = (YFX_W + 1)'(GROUND_Y << FRAC_W);
  localparam logic signed [VY_W-1:0]  L_JUMP_VEL   = VY_W'(JUMP_VEL);
  localparam logic signed [VY_W:0]    L_GRAVITY    = (VY_W + 1)'(GRAVITY);
  localparam logic signed [VY_W:0]    L_MAX_FALL_W = (VY_W + 1)'(MAX_FALL_VEL);
  localparam logic signed [VY_W-1:0]  L_MAX_FALL   = VY_W'(MAX_FALL_VEL);
  localparam logic [CNT_W-1:0]        L_SMASH_CNT  = CNT_W'(SMASH_FRAMES);
  localparam logic [COOL_W-1:0]       L_COOL       = COOL_W'(SMASH_COOL);

  pika_state_e             r_state;
  logic [POS_W-1:0]        r_x;
  logic [YFX_W-1:0]        r_y_fx;
  logic signed [VY_W-1:0]  r_vy;
  logic [CNT_W-1:0]        r_cnt;
  logic [COOL_W-1:0]       r_cool;
  logic                    r_move_l;
  logic                    r_move_r;

  pika_state_e             w_state_nxt;
  logic [POS_W-1:0]        w_x_nxt;
  logic [YFX_W-1:0]        w_y_nxt;
  logic signed [VY_W-1:0]  w_vy_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [COOL_W-1:0]       w_cool_nxt;
  logic                    w_move_l_nxt;
  logic                    w_move_r_nxt;

  logic                    w_jump_req;
  logic                    w_smash_req;
  logic                    w_left_only;
  logic                    w_right_only;
  logic signed [VY_W:0]    w_vy_sum;
  logic signed [VY_W-1:0]  w_vy_grav;
  logic signed [YFX_W:0]   w_y_sum;
  logic                    w_land;

  btn_edge_latch u_jump_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_btn     (io_bus.btn_jump),
    .i_consume (io_bus.frame_tick),
    .i_clear   (io_bus.round_reset),
    .o_req     (w_jump_req)
  );

  btn_edge_latch u_smash_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_btn     (io_bus.btn_smash),
    .i_consume (io_bus.frame_tick),
    .i_clear   (io_bus.round_reset),
    .o_req     (w_smash_req)
  );

  assign w_left_only  = io_bus.btn_left & ~io_bus.btn_right;
  assign w_right_only = io_bus.btn_right & ~io_bus.btn_left;

  // Ballistic step in 10.6 fixed point: gravity with fall-speed saturation, then land check
  assign w_vy_sum  = $signed({r_vy[VY_W-1], r_vy}) + L_GRAVITY;
  assign w_vy_grav = (w_vy_sum > L_MAX_FALL_W) ? L_MAX_FALL : w_vy_sum[VY_W-1:0];
  assign w_y_sum   = $signed({1'b0, r_y_fx})
                   + $signed({{(YFX_W + 1 - VY_W){w_vy_grav[VY_W-1]}}, w_vy_grav});
  assign w_land    = (w_y_sum >= L_GROUND_CMP);

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y_fx;
    w_vy_nxt     = r_vy;
    w_cnt_nxt    = r_cnt;
    w_cool_nxt   = r_cool;
    w_move_l_nxt = r_move_l;
    w_move_r_nxt = r_move_r;

    if (io_bus.round_reset) begin
      w_state_nxt  = ST_GROUND;
      w_x_nxt      = L_INIT_X;
      w_y_nxt      = L_GROUND_FX;
      w_vy_nxt     = '0;
      w_cnt_nxt    = '0;
      w_cool_nxt   = '0;
      w_move_l_nxt = 1'b0;
      w_move_r_nxt = 1'b0;
    end else if (io_bus.frame_tick) begin
      w_move_l_nxt = w_left_only;
      w_move_r_nxt = w_right_only;
      if (w_left_only) begin
        w_x_nxt = (r_x < L_LEFT_LIM) ? L_X_MIN : r_x - L_STEP;
      end else if (w_right_only) begin
        w_x_nxt = (r_x > L_RIGHT_LIM) ? L_X_MAX : r_x + L_STEP;
      end

      w_cool_nxt = (r_cool != '0) ? r_cool - COOL_W'(1) : '0;

      // A landing wins over everything else in the air, including a fresh smash request
      case (r_state)
        ST_GROUND: begin
          if (w_jump_req) begin
            w_vy_nxt    = L_JUMP_VEL;
            w_state_nxt = ST_AIR;
          end
        end
        ST_AIR, ST_SMASH: begin
          if (w_land) begin
            w_y_nxt     = L_GROUND_FX;
            w_vy_nxt    = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_GROUND;
            if (r_state == ST_SMASH) begin
              w_cool_nxt = L_COOL;
            end
          end else begin
            w_y_nxt  = w_y_sum[YFX_W-1:0];
            w_vy_nxt = w_vy_grav;
            if (r_state == ST_AIR) begin
              if (w_smash_req && (r_cool == '0)) begin
                w_cnt_nxt   = L_SMASH_CNT;
                w_state_nxt = ST_SMASH;
              end
            end else if (r_cnt <= CNT_W'(1)) begin
              w_cnt_nxt   = '0;
              w_cool_nxt  = L_COOL;
              w_state_nxt = ST_AIR;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_GROUND;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_GROUND;
      r_x      <= L_INIT_X;
      r_y_fx   <= L_GROUND_FX;
      r_vy     <= '0;
      r_cnt    <= '0;
      r_cool   <= '0;
      r_move_l <= 1'b0;
      r_move_r <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y_fx   <= w_y_nxt;
      r_vy     <= w_vy_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cool   <= w_cool_nxt;
      r_move_l <= w_move_l_nxt;
      r_move_r <= w_move_r_nxt;
    end
  end

  assign io_bus.pos_x         = r_x;
  assign io_bus.pos_y         = r_y_fx[YFX_W-1:FRAC_W];
  assign io_bus.op_move_left  = r_move_l;
  assign io_bus.op_move_right = r_move_r;
  assign io_bus.op_jump       = (r_state != ST_GROUND);
  assign io_bus.is_smash      = (r_state == ST_SMASH);
  assign io_bus.on_ground     = (r_state == ST_GROUND);

endmodule
